// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package regfile_writeback_arbiter_pkg;

    localparam int unsigned RegIdxW = 5;
    localparam int unsigned DataW   = 32;

    localparam logic [RegIdxW-1:0] RegZero = '0;

    // One pending register-file write.
    typedef struct packed {
        logic [RegIdxW-1:0] idx;
        logic [DataW-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Handshake bundle between the pipeline/MDU/hazard unit and the write-back arbiter.
interface regfile_writeback_arbiter_if;
    import regfile_writeback_arbiter_pkg::*;

    logic               wb_valid;
    logic [RegIdxW-1:0] wb_reg;
    logic [DataW-1:0]   wb_data;
    logic               mdu_valid;
    logic               mdu_ready;
    logic [RegIdxW-1:0] mdu_reg;
    logic [DataW-1:0]   mdu_data;
    logic [RegIdxW-1:0] query_reg;
    logic               query_hit;
    logic               stall_req;
    logic               reg_write;
    logic [RegIdxW-1:0] write_reg;
    logic [DataW-1:0]   write_data;

    // Arbiter side.
    modport master (
        input  wb_valid, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, query_reg,
        output mdu_ready, query_hit, stall_req, reg_write, write_reg, write_data
    );

    // Pipeline / MDU / hazard-unit side.
    modport slave (
        output wb_valid, wb_reg, wb_data, mdu_valid, mdu_reg, mdu_data, query_reg,
        input  mdu_ready, query_hit, stall_req, reg_write, write_reg, write_data
    );

endinterface

// File: rtl/regfile_writeback_arbiter_wb_fifo.sv
// In-order FIFO of pending MDU writes with a parallel destination-tag lookup.
module regfile_writeback_arbiter_wb_fifo
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  wb_entry_t          push_entry_i,
    input  logic               pop_i,
    output wb_entry_t          head_o,
    output logic               full_o,
    output logic               empty_o,
    input  logic [RegIdxW-1:0] query_reg_i,
    output logic               query_hit_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    wb_entry_t       mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok, pop_ok;
    logic [PtrW-1:0] offs;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next state; pointers wrap naturally at Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
        if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity comes from the pointers, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        query_hit_o = 1'b0;
        offs        = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            offs = PtrW'(i) - rd_ptr_q;
            if ((CntW'(offs) < count_q) && (mem_q[i].idx == query_reg_i) &&
                (query_reg_i != RegZero)) begin
                query_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline WB writes and queued MDU results onto the single register-file write port.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned StarveLimit = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    regfile_writeback_arbiter_if.master bus_io
);

    localparam int unsigned AgeW = $clog2(StarveLimit + 1);

    wb_entry_t          push_entry, head;
    logic               push, pop, wb_take;
    logic               fifo_full, fifo_empty;
    logic               reg_write_q, reg_write_d;
    logic [RegIdxW-1:0] write_reg_q, write_reg_d;
    logic [DataW-1:0]   write_data_q, write_data_d;
    logic [AgeW-1:0]    age_q, age_d;
    logic               stall_q, stall_d;

    // Register-0 results are acknowledged but never stored.
    assign push            = bus_io.mdu_valid && !fifo_full && (bus_io.mdu_reg != RegZero);
    assign push_entry.idx  = bus_io.mdu_reg;
    assign push_entry.data = bus_io.mdu_data;

    regfile_writeback_arbiter_wb_fifo #(
        .Depth (Depth)
    ) u_wb_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .query_reg_i  (bus_io.query_reg),
        .query_hit_o  (bus_io.query_hit)
    );

    // Slot select: a real pipeline write wins, otherwise the FIFO head drains.
    always_comb begin
        wb_take      = bus_io.wb_valid && (bus_io.wb_reg != RegZero);
        pop          = !wb_take && !fifo_empty;
        reg_write_d  = wb_take || pop;
        write_reg_d  = RegZero;
        write_data_d = '0;
        if (wb_take) begin
            write_reg_d  = bus_io.wb_reg;
            write_data_d = bus_io.wb_data;
        end else if (pop) begin
            write_reg_d  = head.idx;
            write_data_d = head.data;
        end
    end

    // Head-of-queue age and the stall request it drives.
    always_comb begin
        age_d   = age_q;
        stall_d = stall_q;
        if (fifo_empty || pop) begin
            age_d = '0;
        end else if (age_q != AgeW'(StarveLimit)) begin
            age_d = age_q + AgeW'(1);
        end
        if (pop) begin
            stall_d = 1'b0;
        end else if (age_q == AgeW'(StarveLimit)) begin
            stall_d = 1'b1;
        end
    end

    // Output and starvation state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= RegZero;
            write_data_q <= '0;
            age_q        <= '0;
            stall_q      <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            age_q        <= age_d;
            stall_q      <= stall_d;
        end
    end

    assign bus_io.mdu_ready  = !fifo_full;
    assign bus_io.stall_req  = stall_q;
    assign bus_io.reg_write  = reg_write_q;
    assign bus_io.write_reg  = write_reg_q;
    assign bus_io.write_data = write_data_q;

endmodule
